dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Two-requester arbiter sharing the single-port 256x16 data memory between the CPU load/store stage and an external DMA/debug port.
- Grants at most one access per cycle and drives the memory's mem_read/mem_write/addr/write_data.
- Registers read data back to the winning requester with a 1-cycle valid pulse.
- Fixed CPU priority with an anti-starvation counter; optional round-robin mode.

Parameters:
- MAX_WAIT, 4, consecutive cycles ext may be denied while requesting before it is force-granted (1..15).
- LOCK_MAX, 8, maximum consecutive cycles ext may hold the memory via ext_lock (1..255).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- cpu_req  input  1  CPU access request, held until cpu_gnt
- cpu_we  input  1  1=write, 0=read
- cpu_addr  input  9  byte address
- cpu_wdata  input  16  write data
- cpu_gnt  output  1  combinational grant, access performed this cycle
- cpu_rvalid  output  1  registered read-data valid, 1-cycle pulse
- cpu_rdata  output  16  registered read data
- ext_req, ext_we, ext_addr[8:0], ext_wdata[15:0]  input  as CPU equivalents
- ext_lock  input  1  keep ext ownership on following cycles
- ext_gnt, ext_rvalid, ext_rdata[15:0]  output  as CPU equivalents
- mem_read  output  1  to memory
- mem_write  output  1  to memory
- mem_addr  output  9  to memory, selected requester address unchanged (bit 0 passed through)
- mem_write_data  output  16  to memory
- mem_read_data  input  16  from memory, combinational

Behaviour:
- Reset (async): cpu_rvalid, ext_rvalid = 0; cpu_rdata, ext_rdata = 0; starve_cnt = 0; lock_cnt = 0; owner = NONE; last_gnt = CPU.
- Grant decision is combinational from current requests and registered state. Exactly zero or one of cpu_gnt/ext_gnt is high.
- Winner selection, first matching rule applies:
  1. LOCKED: owner==EXT, ext_req=1, ext_lock was 1 on the previous granted cycle, and lock_cnt<LOCK_MAX -> ext wins.
  2. starve_cnt==MAX_WAIT and ext_req -> ext wins.
  3. cpu_req -> cpu wins.
  4. ext_req -> ext wins.
  5. Otherwise no grant.
- Memory side:
  - No grant: mem_read = mem_write = 0; mem_addr and mem_write_data = 0.
  - Grant: mem_write = winner_we; mem_read = ~winner_we; addr/wdata muxed from the winner.
- Read return: on the posedge ending a granted read, the winner's rdata <= mem_read_data and its rvalid <= 1. The other requester's rvalid <= 0; its rdata holds its value. Latency is 1 cycle grant-to-rvalid. Back-to-back reads give rvalid every cycle. Writes never raise rvalid.
- starve_cnt:
  - Increments, saturating at MAX_WAIT, each cycle ext_req=1 and ext_gnt=0.
  - Clears on ext_gnt or ext_req=0.
- lock_cnt:
  - Increments, saturating, each cycle ext is granted with ext_lock=1.
  - Clears when ext is not granted or ext_lock=0.
  - When lock_cnt reaches LOCK_MAX, the lock releases and normal arbitration resumes next cycle.
- owner register = winner of the last cycle (NONE if no grant).
- Requester deasserting req before grant is legal. No state is retained for it except starve_cnt clearing.
- Reset mid-access: any pending rvalid is dropped, and rdata returns to 0.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined: rules 2 and 3 are replaced by round-robin. When both request, the requester not equal to last_gnt wins; last_gnt updates on every grant. starve_cnt is held at 0. Locking is unchanged.
- Undefined: fixed CPU priority with starvation counter as above.

Test Plan:
- Reset with cpu_req=1 held -> all outputs 0 during reset; after release cpu_gnt=1, mem_read=1 same cycle.
- CPU write addr 0x010 data 0xBEEF, then CPU read 0x010 -> mem_write=1 at cycle 0; cpu_rvalid=1, cpu_rdata=0xBEEF one cycle after the read grant.
- cpu_req and ext_req both held continuously, MAX_WAIT=4 -> cpu_gnt for 4 cycles, ext_gnt on cycle 5, pattern repeats; ext_rvalid only after ext read grants.
- ext_lock=1 with both requesting, LOCK_MAX=8 -> ext granted 8 consecutive cycles (after first win), then cpu_gnt the next cycle.
- With DMEM_ARB_RR_EN, both requesting -> grants alternate ext, cpu, ext, cpu starting from last_gnt=CPU after reset.
- Read granted, then rst_n asserted before the next edge -> cpu_rvalid stays 0 and cpu_rdata = 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (CPU, ext DMA/debug) for the shared single-port data memory.
// Define DMEM_ARB_RR_EN to replace fixed CPU priority and starvation counting with round-robin.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [8:0]  cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rdata,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [8:0]  ext_addr,
  input  logic [15:0] ext_wdata,
  input  logic        ext_lock,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [15:0] ext_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [8:0]  mem_addr,
  output logic [15:0] mem_write_data,
  input  logic [15:0] mem_read_data
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_EXT} owner_t;

  owner_t      owner_q, owner_d;
  logic        lock_prev_q, lock_prev_d;
  logic [3:0]  starve_q, starve_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        locked;

`ifdef DMEM_ARB_RR_EN
  typedef enum logic {LAST_CPU, LAST_EXT} last_t;
  last_t last_q, last_d;
`endif

  // Grants are suppressed while reset is held so nothing reaches the memory.
  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    locked  = (owner_q == OWN_EXT) && ext_req && lock_prev_q && (lock_cnt_q < LOCK_MAX_C);
    if (rst_n) begin
      if (locked) begin
        ext_gnt = 1'b1;
`ifdef DMEM_ARB_RR_EN
      end else if (cpu_req && ext_req) begin
        if (last_q == LAST_CPU) ext_gnt = 1'b1;
        else                    cpu_gnt = 1'b1;
`else
      end else if (ext_req && (starve_q == MAX_WAIT_C)) begin
        ext_gnt = 1'b1;
`endif
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (ext_req) begin
        ext_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    if (cpu_gnt) begin
      mem_write      = cpu_we;
      mem_read       = ~cpu_we;
      mem_addr       = cpu_addr;
      mem_write_data = cpu_wdata;
    end else if (ext_gnt) begin
      mem_write      = ext_we;
      mem_read       = ~ext_we;
      mem_addr       = ext_addr;
      mem_write_data = ext_wdata;
    end
  end

  always_comb begin
    owner_d     = OWN_NONE;
    lock_prev_d = ext_gnt & ext_lock;
    starve_d    = '0;
    lock_cnt_d  = '0;
    if (cpu_gnt) owner_d = OWN_CPU;
    if (ext_gnt) owner_d = OWN_EXT;
`ifndef DMEM_ARB_RR_EN
    if (ext_req && !ext_gnt)
      starve_d = (starve_q == MAX_WAIT_C) ? starve_q : starve_q + 4'd1;
`endif
    if (ext_gnt && ext_lock)
      lock_cnt_d = (lock_cnt_q == LOCK_MAX_C) ? lock_cnt_q : lock_cnt_q + 8'd1;
  end

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    last_d = last_q;
    if (cpu_gnt) last_d = LAST_CPU;
    if (ext_gnt) last_d = LAST_EXT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= LAST_CPU;
    else        last_q <= last_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= OWN_NONE;
      lock_prev_q <= 1'b0;
      starve_q    <= '0;
      lock_cnt_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      lock_prev_q <= lock_prev_d;
      starve_q    <= starve_d;
      lock_cnt_q  <= lock_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_gnt & ~cpu_we;
      ext_rvalid <= ext_gnt & ~ext_we;
      if (cpu_gnt && !cpu_we) cpu_rdata <= mem_read_data;
      if (ext_gnt && !ext_we) ext_rdata <= mem_read_data;
    end
  end

endmodule
